// File: rtl/ifid_skid_stage.sv
// ---------------------------------------------------------------------------
// ifid_skid_stage
//
// IF/ID pipeline boundary register with a valid/ready handshake and a
// two-entry skid buffer. It carries the fetched instruction and PC+2 from
// fetch to decode. Backpressure from decode never drops an accepted entry.
// The stage also supports flush-to-NOP, reports its occupancy, and keeps a
// saturating count of stall cycles.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   flush        synchronous flush; discards held and incoming entries
//   in_valid     fetch presents a valid instruction
//   in_ready     stage can accept an entry this cycle (registered)
//   inst         fetched instruction            [INST_W]
//   PC_Plus2     PC+2 of the fetched instruction [PC_W]
//   out_valid    instReg/PC_Plus2Reg hold a valid entry
//   out_ready    decode consumes the entry this cycle
//   instReg      instruction to decode (NOP_INST when not valid)
//   PC_Plus2Reg  PC+2 to decode (zero when not valid)
//   occupancy    number of held entries: 0, 1 or 2
//   stall_cnt    cycles with out_valid=1 and out_ready=0, saturating
// ---------------------------------------------------------------------------
module ifid_skid_stage #(
  parameter int                  INST_W   = 16,
  parameter int                  PC_W     = 16,
  parameter logic [INST_W-1:0]   NOP_INST = {INST_W{1'b0}},
  parameter int                  CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  input  logic [PC_W-1:0]   PC_Plus2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] instReg,
  output logic [PC_W-1:0]   PC_Plus2Reg,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Occupancy state is encoded directly by the two valid bits
  // {main_valid, skid_valid}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BAD   = 2'b01,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  logic              r_main_valid;
  logic [INST_W-1:0] r_main_inst;
  logic [PC_W-1:0]   r_main_pc;
  logic              r_skid_valid;
  logic [INST_W-1:0] r_skid_inst;
  logic [PC_W-1:0]   r_skid_pc;
  logic [CNT_W-1:0]  r_stall_cnt;

  state_t            w_state;
  logic              w_accept;
  logic              w_pop;
  logic              w_cnt_max;

  assign w_state   = state_t'({r_main_valid, r_skid_valid});
  // in_ready depends only on the skid register, so there is no
  // combinational path from out_ready to in_ready.
  assign w_accept  = in_valid & ~r_skid_valid;
  assign w_pop     = r_main_valid & out_ready;
  assign w_cnt_max = (r_stall_cnt == {CNT_W{1'b1}});

  // Main/skid slot update: flush beats accept/pop; skid always drains
  // into main before any newer entry can reach main.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_inst  <= {INST_W{1'b0}};
      r_main_pc    <= {PC_W{1'b0}};
      r_skid_valid <= 1'b0;
      r_skid_inst  <= {INST_W{1'b0}};
      r_skid_pc    <= {PC_W{1'b0}};
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_valid <= 1'b1;
            r_main_inst  <= inst;
            r_main_pc    <= PC_Plus2;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            r_main_inst <= inst;
            r_main_pc   <= PC_Plus2;
          end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_inst  <= inst;
            r_skid_pc    <= PC_Plus2;
          end else if (w_pop) begin
            r_main_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_main_inst  <= r_skid_inst;
            r_main_pc    <= r_skid_pc;
            r_skid_valid <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: recover to empty.
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter; only reset clears it, flush freezes it
  // for that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (r_main_valid && !out_ready && !flush && !w_cnt_max) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // Output data masking: decode sees NOP and a zero PC when nothing is held.
  always_comb begin
    if (r_main_valid) begin
      instReg     = r_main_inst;
      PC_Plus2Reg = r_main_pc;
    end else begin
      instReg     = NOP_INST;
      PC_Plus2Reg = {PC_W{1'b0}};
    end
  end

  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_ifid_skid_stage
//
// Self-checking bench for ifid_skid_stage. A depth-2 FIFO scoreboard is
// pushed on every accepted input and popped when decode consumes an entry;
// the popped entry is compared against the DUT outputs. A table of vectors
// with hand-derived post-edge expectations covers streaming, backpressure,
// flush and simultaneous accept/pop, and hand-written sequences cover
// stall-counter saturation and asynchronous reset at full occupancy.
// ---------------------------------------------------------------------------
module tb_ifid_skid_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] inst;
  logic [15:0] PC_Plus2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instReg;
  logic [15:0] PC_Plus2Reg;
  logic [1:0]  occupancy;
  logic [7:0]  stall_cnt;

  ifid_skid_stage #(
    .INST_W  (16),
    .PC_W    (16),
    .NOP_INST(16'h0000),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inst       (inst),
    .PC_Plus2   (PC_Plus2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instReg    (instReg),
    .PC_Plus2Reg(PC_Plus2Reg),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } ent_t;

  typedef struct packed {
    logic        v;
    logic [15:0] inst;
    logic [15:0] pc;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [15:0] e_inst;
    logic [15:0] e_pc;
    logic [1:0]  e_occ;
    logic        e_rdy;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  ent_t q[$];
  int   m_cnt;
  int   n_vec;
  int   n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: update the reference FIFO from the pre-edge inputs, pop and
  // compare consumed entries, then check all outputs after the edge.
  task automatic step();
    ent_t e;
    bit   had_valid;
    bit   pop;
    bit   acc;
    had_valid = (q.size() != 0);
    pop = had_valid && out_ready;
    acc = in_valid && (q.size() < 2);
    if (!flush && had_valid && !out_ready && m_cnt < 255) m_cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) begin
        e = q.pop_front();
        chk("sb_inst", 32'(instReg), 32'(e.inst));
        chk("sb_pc", 32'(PC_Plus2Reg), 32'(e.pc));
      end
      if (acc) q.push_back('{inst, PC_Plus2});
    end
    @(posedge clk);
    #1;
    chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("m_occupancy", 32'(occupancy), 32'(q.size()));
    chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (q.size() != 0) begin
      chk("m_inst", 32'(instReg), 32'(q[0].inst));
      chk("m_pc", 32'(PC_Plus2Reg), 32'(q[0].pc));
    end else begin
      chk("m_nop_inst", 32'(instReg), 32'h0000);
      chk("m_nop_pc", 32'(PC_Plus2Reg), 32'h0000);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] p,
                       input logic ordy, input logic fl);
    in_valid  = v;
    inst      = i;
    PC_Plus2  = p;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_cnt = 0;

    //        v     inst      pc        ordy  fl    ov    e_inst    e_pc      occ    rdy
    // streaming
    tbl[0]  = '{1'b1, 16'h0A0A, 16'h2222, 1'b1, 1'b0, 1'b1, 16'h0A0A, 16'h2222, 2'd1, 1'b1};
    tbl[1]  = '{1'b1, 16'h1111, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h1111, 16'hFFFF, 2'd1, 1'b1};
    tbl[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1};
    // backpressure, then drain
    tbl[3]  = '{1'b1, 16'h0A0A, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h2222, 2'd1, 1'b1};
    tbl[4]  = '{1'b1, 16'h1111, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h2222, 2'd2, 1'b0};
    tbl[5]  = '{1'b1, 16'h5555, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h2222, 2'd2, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1111, 16'hFFFF, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1};
    // flush at occupancy 2 with an incoming entry
    tbl[8]  = '{1'b1, 16'h0A0A, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h2222, 2'd1, 1'b1};
    tbl[9]  = '{1'b1, 16'h1111, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h2222, 2'd2, 1'b0};
    tbl[10] = '{1'b1, 16'h2222, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1};
    // simultaneous accept and pop at occupancy 1
    tbl[12] = '{1'b1, 16'h0A0A, 16'h2222, 1'b1, 1'b0, 1'b1, 16'h0A0A, 16'h2222, 2'd1, 1'b1};
    tbl[13] = '{1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0, 1'b1, 16'h3333, 16'h4444, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1};
    // flush wins over simultaneous accept and pop
    tbl[15] = '{1'b1, 16'h7777, 16'h8888, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h8888, 2'd1, 1'b1};
    tbl[16] = '{1'b1, 16'h9999, 16'hAAAA, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1};

    // reset state
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_inst", 32'(instReg), 32'h0000);
    chk("rst_pc", 32'(PC_Plus2Reg), 32'h0000);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].v, tbl[i].inst, tbl[i].pc, tbl[i].ordy, tbl[i].fl);
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_inst", i), 32'(instReg), 32'(tbl[i].e_inst));
      chk($sformatf("v%0d_pc", i), 32'(PC_Plus2Reg), 32'(tbl[i].e_pc));
      chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
    end

    // stall counter saturation
    drive(1'b1, 16'hBEEF, 16'h0100, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step();
    chk("stall_sat", 32'(stall_cnt), 32'd255);
    chk("stall_hold_inst", 32'(instReg), 32'hBEEF);

    // fill to two, then flush: counter unaffected
    drive(1'b1, 16'hCAFE, 16'h0102, 1'b0, 1'b0);
    step();
    chk("pre_flush_occ", 32'(occupancy), 32'd2);
    drive(1'b1, 16'h2222, 16'h0104, 1'b0, 1'b1);
    step();
    chk("flush_stall_kept", 32'(stall_cnt), 32'd255);
    chk("flush_occ", 32'(occupancy), 32'd0);

    // refill to two, then assert reset between edges
    drive(1'b1, 16'h1234, 16'h0200, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h5678, 16'h0202, 1'b0, 1'b0);
    step();
    chk("prereset_occ", 32'(occupancy), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_inst", 32'(instReg), 32'h0000);
    chk("arst_pc", 32'(PC_Plus2Reg), 32'h0000);
    chk("arst_occ", 32'(occupancy), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    chk("arst_stall", 32'(stall_cnt), 32'h0);
    q.delete();
    m_cnt = 0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // operation resumes after reset
    drive(1'b1, 16'h6A6A, 16'h0300, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
